// File: rtl/aoi_pkg.sv
// Shared encodings and constants for the AOI filter bank.
package aoi_pkg;

  localparam logic [1:0] MODE_REG   = 2'd0;
  localparam logic [1:0] MODE_FILT  = 2'd1;
  localparam logic [1:0] MODE_LATCH = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Idle level of a NOR-style gate output; also the reset value of out.
  localparam logic OUT_IDLE = 1'b1;

  // Deglitch counter width: enough to count to FILTER-1, never zero bits.
  function automatic int unsigned cnt_width(input int unsigned filter);
    int unsigned w;
    w = $clog2(filter);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aoi_filter_chan.sv
// One AOI gate with its registered / deglitched / strobe-latched output and fall pulse.
module aoi_filter_chan
  import aoi_pkg::*;
#(
  parameter int unsigned TERMS  = 2,
  parameter int unsigned INPUTS = 2,
  parameter int unsigned FILTER = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TERMS*INPUTS-1:0]   gin,
  input  logic [1:0]                mode,
  input  logic                      mode_changed,
  input  logic                      strobe,
  output logic                      raw,
  output logic                      out,
  output logic                      fall
);

  localparam int unsigned CW = cnt_width(FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic [TERMS-1:0] term;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             out_nxt;

  // AND terms of the gate.
  always_comb begin
    term = '0;
    for (int t = 0; t < TERMS; t++) begin
      term[t] = &gin[t*INPUTS +: INPUTS];
    end
  end

  assign raw = ~|term;

  // Next output level and deglitch count; a mode change freezes out and clears the count.
  always_comb begin
    out_nxt = out;
    cnt_nxt = '0;
    if (!mode_changed) begin
      case (mode)
        MODE_FILT: begin
          if (raw != out) begin
            if (cnt == CNT_LAST) begin
              out_nxt = raw;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
        MODE_LATCH: begin
          if (strobe) begin
            out_nxt = raw;
          end
        end
        default: begin
          out_nxt = raw;
        end
      endcase
    end
  end

  // State registers; fall flags the cycle out first reads 0 after reading 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= OUT_IDLE;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      out  <= out_nxt;
      cnt  <= cnt_nxt;
      fall <= out & ~out_nxt;
    end
  end

endmodule

// File: rtl/aoi_filter_bank.sv
// Bank of independent AOI channels sharing mode, strobe and mode-change detection.
module aoi_filter_bank
  import aoi_pkg::*;
#(
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned TERMS    = 2,
  parameter int unsigned INPUTS   = 2,
  parameter int unsigned FILTER   = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [1:0]                         mode,
  input  logic                               strobe,
  input  logic [CHANNELS*TERMS*INPUTS-1:0]   gin,
  output logic [CHANNELS-1:0]                raw,
  output logic [CHANNELS-1:0]                out,
  output logic [CHANNELS-1:0]                fall
);

  localparam int unsigned CW_IN = TERMS * INPUTS;

  logic [1:0] mode_prev;
  logic       mode_changed;

  // Previous-cycle mode, used to detect the first cycle of a new mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev <= MODE_REG;
    end else begin
      mode_prev <= mode;
    end
  end

  assign mode_changed = (mode != mode_prev);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    aoi_filter_chan #(
      .TERMS  (TERMS),
      .INPUTS (INPUTS),
      .FILTER (FILTER)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .gin          (gin[c*CW_IN +: CW_IN]),
      .mode         (mode),
      .mode_changed (mode_changed),
      .strobe       (strobe),
      .raw          (raw[c]),
      .out          (out[c]),
      .fall         (fall[c])
    );
  end

endmodule

// File: tb/tb_aoi_filter_bank.sv
// Scoreboard bench for aoi_filter_bank: directed vectors plus a small-configuration sweep.
module tb_aoi_filter_bank;

  typedef struct {
    logic [5:0] raw;
    logic [5:0] out;
    logic [5:0] fall;
  } exp_t;

  typedef struct {
    logic [11:0] g;
    logic        e;
  } sweep_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        strobe;
  logic [23:0] gin;
  logic [5:0]  raw;
  logic [5:0]  out;
  logic [5:0]  fall;

  logic [1:0]  mode_r;
  logic [1:0]  mode_f;
  logic [11:0] gin_s;
  logic        raw_r, out_r, fall_r;
  logic        raw_f, out_f, fall_f;

  exp_t   sb[$];
  sweep_t sb2[$];

  int n_chk;
  int n_fail;
  int step_idx;

  aoi_filter_bank u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode),
    .strobe (strobe),
    .gin    (gin),
    .raw    (raw),
    .out    (out),
    .fall   (fall)
  );

  aoi_filter_bank #(.CHANNELS(1), .TERMS(4), .INPUTS(3), .FILTER(1)) u_sw_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode_r),
    .strobe (strobe),
    .gin    (gin_s),
    .raw    (raw_r),
    .out    (out_r),
    .fall   (fall_r)
  );

  aoi_filter_bank #(.CHANNELS(1), .TERMS(4), .INPUTS(3), .FILTER(1)) u_sw_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .mode   (mode_f),
    .strobe (strobe),
    .gin    (gin_s),
    .raw    (raw_f),
    .out    (out_f),
    .fall   (fall_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written 4x3 AOI reference.
  function automatic logic aoi_ref(input logic [11:0] g);
    return ~((g[0] & g[1] & g[2]) | (g[3] & g[4] & g[5]) |
             (g[6] & g[7] & g[8]) | (g[9] & g[10] & g[11]));
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Monitor: async-reset checks on rst_n fall, scoreboard pops after each rising edge.
  initial begin
    exp_t   e;
    sweep_t s;
    int     idx;
    int     sidx;
    idx  = 0;
    sidx = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk !== 1'b1) begin
        #1;
        chk("async_rst_out", idx, 32'(out), 32'h3F);
        chk("async_rst_fall", idx, 32'(fall), 32'h00);
      end else begin
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("raw", idx, 32'(raw), 32'(e.raw));
          chk("out", idx, 32'(out), 32'(e.out));
          chk("fall", idx, 32'(fall), 32'(e.fall));
          idx++;
        end
        if (sb2.size() > 0) begin
          s = sb2.pop_front();
          chk("sweep_raw", sidx, 32'(raw_r), 32'(s.e));
          chk("sweep_reg_out", sidx, 32'(out_r), 32'(s.e));
          chk("sweep_filt_out", sidx, 32'(out_f), 32'(s.e));
          sidx++;
        end
      end
    end
  end

  task automatic step(input logic r, input logic [1:0] m, input logic s, input logic [23:0] g,
                      input logic [5:0] er, input logic [5:0] eo, input logic [5:0] ef);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    mode   = m;
    strobe = s;
    gin    = g;
    e.raw  = er;
    e.out  = eo;
    e.fall = ef;
    sb.push_back(e);
    step_idx++;
  endtask

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    sweep_t s;
    n_chk    = 0;
    n_fail   = 0;
    step_idx = 0;
    rst_n    = 1'b0;
    mode     = 2'd0;
    strobe   = 1'b0;
    gin      = '0;
    mode_r   = 2'd0;
    mode_f   = 2'd1;
    gin_s    = '0;

    // Reset held, then released in REG mode.
    step(0, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(0, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h000003, 6'h3E, 6'h3E, 6'h01);
    step(1, 0, 0, 24'h000003, 6'h3E, 6'h3E, 6'h00);
    step(1, 0, 0, 24'h00000C, 6'h3E, 6'h3E, 6'h00);
    step(1, 0, 0, 24'h000001, 6'h3F, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);

    // FILT: 2-cycle glitch rejected, 3-cycle low accepted, rise filtered too.
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3D, 6'h02);
    step(1, 1, 0, 24'h000030, 6'h3D, 6'h3D, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3D, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3D, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);

    // FILT: all channels change together.
    step(1, 1, 0, 24'h333333, 6'h00, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h333333, 6'h00, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h333333, 6'h00, 6'h00, 6'h3F);
    step(1, 1, 0, 24'h333333, 6'h00, 6'h00, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h00, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h00, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);

    // Mode switch with ch3 counter at 2, then REG tracking, then back to FILT.
    step(1, 1, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h003000, 6'h37, 6'h37, 6'h08);
    step(1, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 0, 0, 24'h003000, 6'h37, 6'h37, 6'h08);
    step(1, 0, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h003000, 6'h37, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h003000, 6'h37, 6'h37, 6'h08);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h37, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h37, 6'h00);
    step(1, 1, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);

    // LATCH: toggling raw without strobe holds, strobe samples.
    step(1, 2, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 2, 0, 24'h000300, 6'h3B, 6'h3F, 6'h00);
    step(1, 2, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 2, 0, 24'h000300, 6'h3B, 6'h3F, 6'h00);
    step(1, 2, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 2, 1, 24'h000300, 6'h3B, 6'h3B, 6'h04);
    step(1, 2, 0, 24'h000000, 6'h3F, 6'h3B, 6'h00);
    step(1, 2, 0, 24'h000300, 6'h3B, 6'h3B, 6'h00);
    step(1, 2, 1, 24'h000000, 6'h3F, 6'h3F, 6'h00);

    // Reserved mode behaves as REG.
    step(1, 3, 0, 24'h000000, 6'h3F, 6'h3F, 6'h00);
    step(1, 3, 0, 24'h300000, 6'h1F, 6'h1F, 6'h20);
    step(1, 3, 0, 24'h300000, 6'h1F, 6'h1F, 6'h00);

    // Asynchronous reset mid-cycle with ch5 low.
    begin
      exp_t e;
      @(negedge clk);
      #2;
      rst_n  = 1'b0;
      e.raw  = 6'h1F;
      e.out  = 6'h3F;
      e.fall = 6'h00;
      sb.push_back(e);
    end

    // Release in FILT: reset mode history is REG, so the first cycle is a mode change.
    step(0, 1, 0, 24'h000003, 6'h3E, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000003, 6'h3E, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000003, 6'h3E, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000003, 6'h3E, 6'h3F, 6'h00);
    step(1, 1, 0, 24'h000003, 6'h3E, 6'h3E, 6'h01);
    step(1, 1, 0, 24'h000003, 6'h3E, 6'h3E, 6'h00);

    // Small-configuration sweep: every 12-bit gin value in scrambled order.
    @(negedge clk);
    gin  = '0;
    mode = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      gin_s = 12'(i * 1237);
      s.g   = gin_s;
      s.e   = aoi_ref(gin_s);
      sb2.push_back(s);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
